// File: rtl/riscv_pkg.sv
// Shared definitions for the instruction-fetch stage: data width, the
// bubble instruction word, fetch FSM state encoding and a PC alignment helper.
package riscv_pkg;

   localparam int XLEN = 32;

   // addi x0,x0,0
   localparam logic [XLEN-1:0] RV_NOP_INSN = 32'h0000_0013;

   typedef enum logic [1:0] {
      FETCH = 2'd0,
      WAIT  = 2'd1,
      DRAIN = 2'd2
   } fetch_state_e;

   // Instruction addresses are always word aligned; the low two bits are dropped.
   function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
      return addr & ~XLEN'(3);
   endfunction

endpackage

// File: rtl/fetch_out_reg.sv
// Output slot of the fetch stage: the register that drives the IF/ID inputs.
// Priority is flush > load > consume > hold. The PC fields keep their last
// value when the slot empties; only the instruction word falls back to the bubble.
module fetch_out_reg
   import riscv_pkg::*;
#(
   parameter logic [XLEN-1:0] NOP_INSN = RV_NOP_INSN
) (
   input  logic            clk,
   input  logic            rst_b,
   input  logic            flush,
   input  logic            load,
   input  logic            consume,
   input  logic [XLEN-1:0] load_pc,
   input  logic [XLEN-1:0] load_data,
   output logic [XLEN-1:0] pc,
   output logic [XLEN-1:0] pc4,
   output logic [XLEN-1:0] idata,
   output logic            valid
);

   // Slot register: synchronous reset, then flush/load/consume/hold.
   always_ff @(posedge clk) begin
      if (!rst_b) begin
         valid <= 1'b0;
         idata <= NOP_INSN;
         pc    <= '0;
         pc4   <= '0;
      end else if (flush) begin
         valid <= 1'b0;
         idata <= NOP_INSN;
      end else if (load) begin
         valid <= 1'b1;
         idata <= load_data;
         pc    <= load_pc;
         pc4   <= load_pc + XLEN'(4);
      end else if (consume) begin
         valid <= 1'b0;
         idata <= NOP_INSN;
      end
   end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, runs a single-outstanding
// request/response handshake with instruction memory and presents one
// instruction at a time to the IF/ID register.
// Optional build macro FETCH_PERF_EN adds PERF_FETCHED / PERF_STALL counters.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   FETCH | no request outstanding; request fetch_pc when slot can take it
//   WAIT  | request granted, response will be presented
//   DRAIN | request granted before a redirect, response will be dropped
module fetch_stage
   import riscv_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
   parameter logic [XLEN-1:0] NOP_INSN = RV_NOP_INSN
) (
   input  logic            CLK,
   input  logic            RST,
   input  logic            STALL,
   input  logic            REDIRECT,
   input  logic [XLEN-1:0] REDIRECT_PC,
   output logic            IMEM_REQ,
   output logic [XLEN-1:0] IMEM_ADDR,
   input  logic            IMEM_GNT,
   input  logic            IMEM_RVALID,
   input  logic [XLEN-1:0] IMEM_RDATA,
   output logic [XLEN-1:0] PC_IF,
   output logic [XLEN-1:0] PC4_IF,
   output logic [XLEN-1:0] IDATA_IF,
   output logic            VALID_IF
`ifdef FETCH_PERF_EN
   ,
   output logic [XLEN-1:0] PERF_FETCHED,
   output logic [XLEN-1:0] PERF_STALL
`endif
);

   fetch_state_e    state;
   fetch_state_e    state_nx;
   logic [XLEN-1:0] fetch_pc;
   logic [XLEN-1:0] fetch_pc_nx;
   logic [XLEN-1:0] issued_pc;

   logic slot_free;
   logic gnt_taken;
   logic resp_live;
   logic load;
   logic consume;

   // The slot can accept a word if it is empty or being consumed this cycle.
   assign slot_free = !VALID_IF || !STALL;
   assign consume   = VALID_IF && !STALL;

   // Requests only go out when the slot will be free by the time the response
   // returns; this is what guarantees WAIT never sees a response with a full slot.
   assign IMEM_REQ  = RST && (state == FETCH) && slot_free;
   assign IMEM_ADDR = fetch_pc;
   assign gnt_taken = IMEM_REQ && IMEM_GNT;

   assign resp_live = (state == WAIT) && IMEM_RVALID;
   assign load      = resp_live && slot_free && !REDIRECT;

   // Next-state and next-PC decode; redirect overrides PC and poisons any
   // transaction still in flight after this cycle.
   always_comb begin
      state_nx    = state;
      fetch_pc_nx = fetch_pc;
      case (state)
         FETCH: begin
            if (gnt_taken) begin
               state_nx    = WAIT;
               fetch_pc_nx = fetch_pc + XLEN'(4);
            end
         end
         WAIT: begin
            if (IMEM_RVALID) state_nx = FETCH;
         end
         DRAIN: begin
            if (IMEM_RVALID) state_nx = FETCH;
         end
         default: state_nx = FETCH;
      endcase
      if (REDIRECT) begin
         fetch_pc_nx = word_align(REDIRECT_PC);
         // A response arriving with the redirect closes the old transaction,
         // so only a still-pending one needs draining.
         if (state_nx != FETCH) state_nx = DRAIN;
      end
   end

   // State, fetch PC and the PC of the request currently in flight.
   always_ff @(posedge CLK) begin
      if (!RST) begin
         state     <= FETCH;
         fetch_pc  <= RESET_PC;
         issued_pc <= RESET_PC;
      end else begin
         state    <= state_nx;
         fetch_pc <= fetch_pc_nx;
         if (gnt_taken) issued_pc <= fetch_pc;
      end
   end

   fetch_out_reg #(
      .NOP_INSN (NOP_INSN)
   ) u_out_reg (
      .clk       (CLK),
      .rst_b     (RST),
      .flush     (REDIRECT),
      .load      (load),
      .consume   (consume),
      .load_pc   (issued_pc),
      .load_data (IMEM_RDATA),
      .pc        (PC_IF),
      .pc4       (PC4_IF),
      .idata     (IDATA_IF),
      .valid     (VALID_IF)
   );

   resp_slot_free_a : assert property (@(posedge CLK) disable iff (!RST)
      (resp_live && !REDIRECT) |-> slot_free);

`ifdef FETCH_PERF_EN
   // Presented-instruction and stalled-cycle counters, free-running with wrap.
   always_ff @(posedge CLK) begin
      if (!RST) begin
         PERF_FETCHED <= '0;
         PERF_STALL   <= '0;
      end else begin
         if (load) PERF_FETCHED <= PERF_FETCHED + XLEN'(1);
         if (VALID_IF && STALL) PERF_STALL <= PERF_STALL + XLEN'(1);
      end
   end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios followed by randomized traffic,
// all checked against a transaction-level model (outstanding/drop flags and
// the presented-slot contents) kept in the bench.
module tb_fetch_stage;

   localparam logic [31:0] NOP      = 32'h0000_0013;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   logic        CLK;
   logic        RST;
   logic        STALL;
   logic        REDIRECT;
   logic [31:0] REDIRECT_PC;
   logic        IMEM_REQ;
   logic [31:0] IMEM_ADDR;
   logic        IMEM_GNT;
   logic        IMEM_RVALID;
   logic [31:0] IMEM_RDATA;
   logic [31:0] PC_IF;
   logic [31:0] PC4_IF;
   logic [31:0] IDATA_IF;
   logic        VALID_IF;
`ifdef FETCH_PERF_EN
   logic [31:0] PERF_FETCHED;
   logic [31:0] PERF_STALL;
`endif

   int tests;
   int fails;

   // reference model state
   logic [31:0] m_pc;
   logic [31:0] m_issued;
   logic [31:0] m_pc_if;
   logic [31:0] m_pc4;
   logic [31:0] m_idata;
   logic        m_valid;
   logic        pend;
   logic        m_drop;
   int          cnt;
   logic [31:0] m_perf_f;
   logic [31:0] m_perf_s;

   fetch_stage #(
      .RESET_PC (RESET_PC),
      .NOP_INSN (NOP)
   ) dut (
      .CLK          (CLK),
      .RST          (RST),
      .STALL        (STALL),
      .REDIRECT     (REDIRECT),
      .REDIRECT_PC  (REDIRECT_PC),
      .IMEM_REQ     (IMEM_REQ),
      .IMEM_ADDR    (IMEM_ADDR),
      .IMEM_GNT     (IMEM_GNT),
      .IMEM_RVALID  (IMEM_RVALID),
      .IMEM_RDATA   (IMEM_RDATA),
      .PC_IF        (PC_IF),
      .PC4_IF       (PC4_IF),
      .IDATA_IF     (IDATA_IF),
      .VALID_IF     (VALID_IF)
`ifdef FETCH_PERF_EN
      ,
      .PERF_FETCHED (PERF_FETCHED),
      .PERF_STALL   (PERF_STALL)
`endif
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
      end
   endtask

   task automatic chk_slot(input string tag);
      chk({tag, "_valid"}, {31'd0, VALID_IF}, {31'd0, m_valid});
      chk({tag, "_idata"}, IDATA_IF, m_idata);
      chk({tag, "_pc_if"}, PC_IF, m_pc_if);
      chk({tag, "_pc4_if"}, PC4_IF, m_pc4);
`ifdef FETCH_PERF_EN
      chk({tag, "_perf_fetched"}, PERF_FETCHED, m_perf_f);
      chk({tag, "_perf_stall"}, PERF_STALL, m_perf_s);
`endif
   endtask

   // Called at a negedge with RST already released; returns at the next negedge.
   task automatic step(input logic s, input logic r, input logic [31:0] rpc,
                       input logic g, input int lat, input logic [31:0] data,
                       input logic stray);
      logic exp_req;
      logic gnt_now;
      logic resp;
      logic free;
      chk_slot("slot");
      STALL       = s;
      REDIRECT    = r;
      REDIRECT_PC = rpc;
      IMEM_GNT    = g;
      IMEM_RVALID = (pend && cnt == 0) || stray;
      IMEM_RDATA  = IMEM_RVALID ? data : $urandom;
      exp_req     = !pend && (!m_valid || !s);
      #1;
      chk("imem_req", {31'd0, IMEM_REQ}, {31'd0, exp_req});
      if (exp_req) chk("imem_addr", IMEM_ADDR, m_pc);
      @(posedge CLK);
      gnt_now = exp_req && g;
      resp    = pend && IMEM_RVALID;
      free    = !m_valid || !s;
      if (m_valid && s) m_perf_s++;
      if (r) begin
         m_valid = 1'b0;
         m_idata = NOP;
      end else if (resp && !m_drop && free) begin
         m_valid = 1'b1;
         m_idata = data;
         m_pc_if = m_issued;
         m_pc4   = m_issued + 32'd4;
         m_perf_f++;
      end else if (m_valid && !s) begin
         m_valid = 1'b0;
         m_idata = NOP;
      end
      if (resp) begin
         pend   = 1'b0;
         m_drop = 1'b0;
      end else if (pend) begin
         cnt--;
      end
      if (gnt_now) begin
         pend     = 1'b1;
         cnt      = lat;
         m_issued = m_pc;
         m_pc     = m_pc + 32'd4;
         m_drop   = 1'b0;
      end
      if (r) begin
         m_pc = {rpc[31:2], 2'b00};
         if (pend) m_drop = 1'b1;
      end
      @(negedge CLK);
   endtask

   // Holds reset for two edges (optionally with a stale response on the bus).
   task automatic do_reset(input logic stale_rv);
      RST         = 1'b0;
      STALL       = 1'b0;
      REDIRECT    = 1'b0;
      REDIRECT_PC = '0;
      IMEM_GNT    = 1'b1;
      IMEM_RVALID = stale_rv;
      IMEM_RDATA  = 32'hDEAD_BEEF;
      #1;
      chk("rst_req_low", {31'd0, IMEM_REQ}, 32'd0);
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      m_pc     = RESET_PC;
      m_issued = RESET_PC;
      m_pc_if  = '0;
      m_pc4    = '0;
      m_idata  = NOP;
      m_valid  = 1'b0;
      pend     = 1'b0;
      m_drop   = 1'b0;
      cnt      = 0;
      m_perf_f = '0;
      m_perf_s = '0;
      chk("rst_req", {31'd0, IMEM_REQ}, 32'd0);
      chk_slot("rst");
      RST         = 1'b1;
      IMEM_GNT    = 1'b0;
      IMEM_RVALID = 1'b0;
   endtask

   initial begin
      tests = 0;
      fails = 0;
      RST = 1'b0;
      STALL = 1'b0;
      REDIRECT = 1'b0;
      REDIRECT_PC = '0;
      IMEM_GNT = 1'b0;
      IMEM_RVALID = 1'b0;
      IMEM_RDATA = '0;
      @(negedge CLK);
      do_reset(1'b0);

      // first fetch: immediate grant, response one cycle later
      step(0, 0, 0, 1, 0, 0, 0);
      step(0, 0, 0, 0, 0, 32'h0050_0093, 0);
      chk("first_valid", {31'd0, VALID_IF}, 32'd1);
      chk("first_pc", PC_IF, 32'h0);
      chk("first_pc4", PC4_IF, 32'h4);
      chk("first_idata", IDATA_IF, 32'h0050_0093);

      // stalled for three cycles: slot held, no request
      for (int i = 0; i < 3; i++) begin
         step(1, 0, 0, 1, 0, 0, 0);
         chk("stall_hold", IDATA_IF, 32'h0050_0093);
      end
      chk("stall_next_addr", IMEM_ADDR, 32'h4);
      step(0, 0, 0, 1, 0, 0, 0);
      step(0, 0, 0, 0, 0, 32'h1111_1111, 0);

      // redirect while waiting; stale word must be dropped
      step(0, 0, 0, 1, 1, 0, 0);
      step(0, 1, 32'h0000_0103, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 32'hDEAD_BEEF, 0);
      chk("redir_valid", {31'd0, VALID_IF}, 32'd0);
      chk("redir_idata", IDATA_IF, NOP);
      chk("redir_addr", IMEM_ADDR, 32'h0000_0100);

      // redirect + response + stall together: straight back to fetching
      step(0, 0, 0, 1, 0, 0, 0);
      step(1, 1, 32'h0000_0208, 0, 0, 32'h2222_2222, 0);
      chk("rrs_valid", {31'd0, VALID_IF}, 32'd0);
      chk("rrs_req", {31'd0, IMEM_REQ}, 32'd1);
      chk("rrs_addr", IMEM_ADDR, 32'h0000_0208);

      // PC wrap at the top of the address space
      step(0, 1, 32'hFFFF_FFFE, 0, 0, 0, 0);
      step(0, 0, 0, 1, 0, 0, 0);
      step(0, 0, 0, 0, 0, 32'h3333_3333, 0);
      chk("wrap_pc", PC_IF, 32'hFFFF_FFFC);
      chk("wrap_pc4", PC4_IF, 32'h0);
      chk("wrap_addr", IMEM_ADDR, 32'h0);

      // reset while a request is outstanding, stale response afterwards
      step(0, 0, 0, 1, 2, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0);
      do_reset(1'b1);
      step(0, 0, 0, 0, 0, 32'hDEAD_BEEF, 1);
      chk("post_rst_valid", {31'd0, VALID_IF}, 32'd0);
      chk("post_rst_addr", IMEM_ADDR, RESET_PC);

      // randomized traffic
      for (int i = 0; i < 600; i++) begin
         logic        s;
         logic        r;
         logic [31:0] rpc;
         s   = ($urandom % 4) == 0;
         r   = ($urandom % 12) == 0;
         rpc = (($urandom % 4) == 0) ? (32'hFFFF_FFF0 | ($urandom % 16)) : $urandom;
         step(s, r, rpc, ($urandom % 3) != 0, int'($urandom_range(0, 3)), $urandom, 0);
      end
      chk_slot("final");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
